// File: rtl/uart_boot_loader_if.sv
// Boot-loader bus: UART byte handshake in, IMEM/DMEM word writes out,
// plus CPU reset / done status. master = loader side, slave = system side.
interface uart_boot_loader_if #(
   parameter int IMEM_AW = 12,
   parameter int DMEM_AW = 12
);
   logic               rvalid_i;
   logic               rready_o;
   logic [7:0]         rdata_i;
   logic               imem_we_o;
   logic [IMEM_AW-1:0] imem_addr_o;
   logic [31:0]        imem_wdata_o;
   logic               dmem_we_o;
   logic [DMEM_AW-1:0] dmem_addr_o;
   logic [31:0]        dmem_wdata_o;
   logic               cpu_rst_o;
   logic               done_o;

   modport master (
      input  rvalid_i, rdata_i,
      output rready_o,
      output imem_we_o, imem_addr_o, imem_wdata_o,
      output dmem_we_o, dmem_addr_o, dmem_wdata_o,
      output cpu_rst_o, done_o
   );

   modport slave (
      output rvalid_i, rdata_i,
      input  rready_o,
      input  imem_we_o, imem_addr_o, imem_wdata_o,
      input  dmem_we_o, dmem_addr_o, dmem_wdata_o,
      input  cpu_rst_o, done_o
   );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: packs LSB-first bytes into 32-bit words, fills IMEM
// then DMEM, and holds the CPU in reset until the last word is written.
// Ports: clk_i, rst_ni (async, active low), bus (uart_boot_loader_if.master).
module uart_boot_loader #(
   parameter int IMEM_ENTRIES = 4096,
   parameter int DMEM_ENTRIES = 4096,
   localparam int IMEM_AW = (IMEM_ENTRIES > 1) ? $clog2(IMEM_ENTRIES) : 1,
   localparam int DMEM_AW = (DMEM_ENTRIES > 1) ? $clog2(DMEM_ENTRIES) : 1
) (
   input logic                clk_i,
   input logic                rst_ni,
   uart_boot_loader_if.master bus
);

   localparam int IDX_W = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW;
   localparam logic [IDX_W-1:0] IMEM_LAST = IDX_W'(IMEM_ENTRIES - 1);
   localparam logic [IDX_W-1:0] DMEM_LAST =
      IDX_W'((DMEM_ENTRIES > 0) ? DMEM_ENTRIES - 1 : 0);

   typedef enum logic [1:0] {
      LOAD_IMEM,
      LOAD_DMEM,
      DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [1:0]       cnt;
   logic [31:0]      sreg;

   logic        accept;
   logic        word_end;
   logic        at_last;
   logic [31:0] word;

   assign accept   = bus.rvalid_i & bus.rready_o;
   assign word_end = accept & (cnt == 2'd3);
   assign word     = {bus.rdata_i, sreg[31:8]};
   assign at_last  = (state == LOAD_IMEM) ? (idx == IMEM_LAST)
                                          : (idx == DMEM_LAST);

   // Writes are issued straight from the 4th-byte edge, so the write
   // stage never stalls and back-to-back bytes are never lost.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state            <= LOAD_IMEM;
         idx              <= '0;
         cnt              <= '0;
         sreg             <= '0;
         bus.rready_o     <= 1'b0;
         bus.imem_we_o    <= 1'b0;
         bus.imem_addr_o  <= '0;
         bus.imem_wdata_o <= '0;
         bus.dmem_we_o    <= 1'b0;
         bus.dmem_addr_o  <= '0;
         bus.dmem_wdata_o <= '0;
         bus.cpu_rst_o    <= 1'b1;
         bus.done_o       <= 1'b0;
      end else begin
         bus.imem_we_o <= 1'b0;
         bus.dmem_we_o <= 1'b0;
         if (accept) begin
            sreg <= word;
            cnt  <= cnt + 2'd1;
         end
         unique case (state)
            LOAD_IMEM, LOAD_DMEM: begin
               bus.rready_o <= 1'b1;
               if (word_end) begin
                  if (state == LOAD_IMEM) begin
                     bus.imem_we_o    <= 1'b1;
                     bus.imem_addr_o  <= idx[IMEM_AW-1:0];
                     bus.imem_wdata_o <= word;
                  end else begin
                     bus.dmem_we_o    <= 1'b1;
                     bus.dmem_addr_o  <= idx[DMEM_AW-1:0];
                     bus.dmem_wdata_o <= word;
                  end
                  if (!at_last) begin
                     idx <= idx + 1'b1;
                  end else begin
                     idx <= '0;
                     if (state == LOAD_IMEM && DMEM_ENTRIES != 0) begin
                        state <= LOAD_DMEM;
                     end else begin
                        // Stop accepting at once: the stream is complete.
                        state        <= DONE;
                        bus.rready_o <= 1'b0;
                     end
                  end
               end
            end
            DONE: begin
               bus.rready_o  <= 1'b0;
               bus.cpu_rst_o <= 1'b0;
               bus.done_o    <= 1'b1;
            end
            default: begin
               state <= LOAD_IMEM;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: random byte streams and gaps against a
// word/stream level model; DUT A has 4/2 entries, DUT B has 4/0 entries.
module tb_uart_boot_loader;
   localparam int IM  = 4;
   localparam int DMA = 2;
   localparam int DMB = 0;
   localparam int IAW = 2;
   localparam int DAW = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_a = 1'b1;
   logic       rst_b = 1'b1;
   logic       sel   = 1'b0;
   logic       rvalid = 1'b0;
   logic [7:0] rdata  = 8'h00;

   uart_boot_loader_if #(.IMEM_AW(IAW), .DMEM_AW(DAW)) bus_a ();
   uart_boot_loader_if #(.IMEM_AW(IAW), .DMEM_AW(DAW)) bus_b ();

   assign bus_a.rvalid_i = rvalid;
   assign bus_a.rdata_i  = rdata;
   assign bus_b.rvalid_i = rvalid;
   assign bus_b.rdata_i  = rdata;

   uart_boot_loader #(.IMEM_ENTRIES(IM), .DMEM_ENTRIES(DMA)) u_a (
      .clk_i(clk), .rst_ni(rst_a), .bus(bus_a));
   uart_boot_loader #(.IMEM_ENTRIES(IM), .DMEM_ENTRIES(DMB)) u_b (
      .clk_i(clk), .rst_ni(rst_b), .bus(bus_b));

   // Outputs of whichever DUT is under test.
   logic           o_rst, o_rready, o_iwe, o_dwe, o_crst, o_done;
   logic [IAW-1:0] o_iaddr;
   logic [DAW-1:0] o_daddr;
   logic [31:0]    o_iwd, o_dwd;
   int             dm;

   assign o_rst    = sel ? rst_b : rst_a;
   assign o_rready = sel ? bus_b.rready_o : bus_a.rready_o;
   assign o_iwe    = sel ? bus_b.imem_we_o : bus_a.imem_we_o;
   assign o_dwe    = sel ? bus_b.dmem_we_o : bus_a.dmem_we_o;
   assign o_crst   = sel ? bus_b.cpu_rst_o : bus_a.cpu_rst_o;
   assign o_done   = sel ? bus_b.done_o : bus_a.done_o;
   assign o_iaddr  = sel ? bus_b.imem_addr_o : bus_a.imem_addr_o;
   assign o_daddr  = sel ? bus_b.dmem_addr_o : bus_a.dmem_addr_o;
   assign o_iwd    = sel ? bus_b.imem_wdata_o : bus_a.imem_wdata_o;
   assign o_dwd    = sel ? bus_b.dmem_wdata_o : bus_a.dmem_wdata_o;
   assign dm       = sel ? DMB : DMA;

   logic [7:0] stream [0:63];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Handshake counter: the model's notion of bytes consumed.
   int hs = 0;
   bit hs_edge = 1'b0;
   int pe = 0;
   always @(posedge clk) begin
      if (!o_rst) begin
         hs      <= 0;
         hs_edge <= 1'b0;
         pe      <= 0;
      end else begin
         pe      <= pe + 1;
         hs_edge <= rvalid && o_rready;
         if (rvalid && o_rready) hs <= hs + 1;
      end
   end

   // Model: word w = bytes 4w..4w+3 little-endian; words < IM go to imem
   // address w, the rest to dmem address w-IM; done after the last one.
   int          n_writes = 0;
   bit          done_exp = 1'b0;
   bit          exp_we, exp_i, exp_d, is_last;
   int          w;
   logic [31:0] ei_addr, ei_data, ed_addr, ed_data, wv;
   always @(negedge clk) begin
      if (!o_rst) begin
         chk("rst_rready", o_rready, 0);
         chk("rst_imem_we", o_iwe, 0);
         chk("rst_dmem_we", o_dwe, 0);
         chk("rst_iaddr", o_iaddr, 0);
         chk("rst_iwdata", o_iwd, 0);
         chk("rst_daddr", o_daddr, 0);
         chk("rst_dwdata", o_dwd, 0);
         chk("rst_cpu_rst", o_crst, 1);
         chk("rst_done", o_done, 0);
         n_writes = 0;
         done_exp = 1'b0;
         ei_addr = 0; ei_data = 0; ed_addr = 0; ed_data = 0;
      end else begin
         w      = hs / 4 - 1;
         exp_we = hs_edge && (hs % 4 == 0) && hs > 0 && w < IM + dm;
         exp_i  = exp_we && (w < IM);
         exp_d  = exp_we && (w >= IM);
         is_last = exp_we && (w == IM + dm - 1);
         if (exp_we) begin
            wv = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            n_writes++;
            if (exp_i) begin
               ei_addr = w;
               ei_data = wv;
            end else begin
               ed_addr = w - IM;
               ed_data = wv;
            end
         end
         chk("imem_we", o_iwe, exp_i);
         chk("dmem_we", o_dwe, exp_d);
         chk("both_we", o_iwe & o_dwe, 0);
         chk("imem_addr", o_iaddr, ei_addr);
         chk("imem_wdata", o_iwd, ei_data);
         chk("dmem_addr", o_daddr, ed_addr);
         chk("dmem_wdata", o_dwd, ed_data);
         chk("done", o_done, done_exp);
         chk("cpu_rst", o_crst, !done_exp);
         if (done_exp) chk("rready_done", o_rready, 0);
         else if (pe >= 1 && !is_last) chk("rready_load", o_rready, 1);
         if (is_last) done_exp = 1'b1;
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      if (sel) rst_b = 1'b1;
      else rst_a = 1'b1;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      rvalid = 1'b1;
      rdata  = b;
      while (o_rready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         chk("rready_timeout", 0, 1);
         rvalid = 1'b0;
         return;
      end
      @(negedge clk);
      rvalid = 1'b0;
   endtask

   task automatic send_stream(input int n, input int maxgap);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, maxgap)) @(negedge clk);
         send(stream[i]);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic load_std();
      logic [31:0] wd [0:5];
      wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
      wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
      wd[4] = 32'hAABB_CCDD; wd[5] = 32'h0000_0777;
      for (int i = 0; i < 6; i++)
         for (int k = 0; k < 4; k++) stream[4*i+k] = wd[i][8*k +: 8];
   endtask

   task automatic load_rand();
      for (int i = 0; i < 64; i++) stream[i] = 8'($urandom);
   endtask

   task automatic check_std_end();
      chk("end_done", o_done, 1);
      chk("end_cpu_rst", o_crst, 0);
      chk("end_rready", o_rready, 0);
      chk("end_iaddr", o_iaddr, 3);
      chk("end_iwdata", o_iwd, 32'h4444_4444);
      chk("end_daddr", o_daddr, 1);
      chk("end_dwdata", o_dwd, 32'h0000_0777);
      chk("end_nwrites", n_writes, 6);
   endtask

   initial begin
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      do_reset();

      // 1: single imem word 0x13, pinned by literal.
      for (int i = 0; i < 64; i++) stream[i] = 8'h00;
      stream[0] = 8'h13;
      for (int i = 0; i < 4; i++) send(stream[i]);
      chk("s1_we", o_iwe, 1);
      chk("s1_addr", o_iaddr, 0);
      chk("s1_wdata", o_iwd, 32'h0000_0013);
      chk("s1_cpu_rst", o_crst, 1);
      repeat (3) @(negedge clk);

      // 2: full stream, small random gaps.
      do_reset();
      load_std();
      send_stream(24, 3);
      check_std_end();

      // 3: back-to-back bytes.
      do_reset();
      send_stream(24, 0);
      check_std_end();

      // 4: gaps of 0..20 cycles.
      do_reset();
      send_stream(24, 20);
      check_std_end();

      // 5: reset after 6 bytes, then the full stream.
      do_reset();
      load_rand();
      send_stream(6, 2);
      do_reset();
      load_std();
      send_stream(24, 1);
      check_std_end();

      // Random data, random gaps.
      for (int r = 0; r < 3; r++) begin
         do_reset();
         load_rand();
         send_stream(24, 5);
         chk("rnd_done", o_done, 1);
         chk("rnd_nwrites", n_writes, 6);
      end

      // 6: DMEM_ENTRIES = 0.
      rst_a = 1'b0;
      sel   = 1'b1;
      do_reset();
      load_rand();
      send_stream(16, 3);
      chk("s6_done", o_done, 1);
      chk("s6_cpu_rst", o_crst, 0);
      chk("s6_nwrites", n_writes, 4);
      rvalid = 1'b1;
      rdata  = 8'h5A;
      repeat (10) @(negedge clk);
      rvalid = 1'b0;
      chk("s6_no_17th", hs, 16);
      chk("s6_rready", o_rready, 0);
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits inside the DUT between the UART receiver and the CPU's instruction and data memories.
- Consumes the serial boot byte stream and assembles little-endian 32-bit words.
- Writes IMEM_ENTRIES words into instruction memory, then DMEM_ENTRIES words into data memory.
- Holds the CPU in reset until the last word is written, then releases it.

Parameters:
IMEM_ENTRIES, 4096, number of 32-bit words loaded into instruction memory (>=1)
DMEM_ENTRIES, 4096, number of 32-bit words loaded into data memory (>=0)
IMEM_AW, $clog2(IMEM_ENTRIES), instruction memory word-address width (derived, min 1)
DMEM_AW, $clog2(DMEM_ENTRIES), data memory word-address width (derived, min 1)

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
rvalid_i  input  1  UART receiver has a byte
rready_o  output  1  loader accepts byte this cycle
rdata_i  input  8  received byte
imem_we_o  output  1  instruction memory write strobe, one cycle per word
imem_addr_o  output  IMEM_AW  instruction memory word index
imem_wdata_o  output  32  instruction word
dmem_we_o  output  1  data memory write strobe, one cycle per word
dmem_addr_o  output  DMEM_AW  data memory word index
dmem_wdata_o  output  32  data word
cpu_rst_o  output  1  active-high CPU reset; high until load completes
done_o  output  1  load complete, sticky until reset

Behaviour:
- Reset (async, rst_ni=0):
  - State is LOAD_IMEM; word index, byte count and shift register are all 0.
  - rready_o=0, both we_o=0, addr/wdata outputs=0.
  - cpu_rst_o=1, done_o=0.
- Reset released mid-load: the loader restarts at imem word 0. No partial word is retained.
- States: LOAD_IMEM -> LOAD_DMEM -> DONE. No other transitions exist except reset.
- rready_o:
  - Registered; equals 1 in LOAD_IMEM and LOAD_DMEM from the first cycle after reset deassertion.
  - Equals 0 in DONE, so the receiver is free for the CPU afterwards.
- Byte accept: a byte is accepted on the rising edge where rvalid_i & rready_o.
  - Shift register updates to {rdata_i, sreg[31:8]}; the 2-bit byte count increments and wraps 3->0.
  - The first byte received lands in bits [7:0] of the word.
- Word write, triggered by the 4th byte (count==3):
  - Next cycle, the active memory's we_o=1 for exactly one cycle.
  - wdata_o = assembled word; addr_o = current word index.
  - The word index increments in the same cycle as the write.
  - Latency: 1 cycle from the 4th-byte handshake edge to the we_o-high cycle.
- Back-to-back bytes every cycle are legal and must not drop data: the write pipeline is one register stage with no stall.
- addr/wdata outputs hold their last value when we_o=0.
- IMEM->DMEM switch: on the write of imem word IMEM_ENTRIES-1, the state becomes LOAD_DMEM and the word index clears to 0. The next byte belongs to dmem word 0.
- DMEM_ENTRIES==0: the state goes LOAD_IMEM -> DONE directly on the last imem write.
- DMEM->DONE: on the write of dmem word DMEM_ENTRIES-1, the state becomes DONE and rready_o drops the following cycle.
  - The cycle after that write, cpu_rst_o goes 0 and done_o goes 1; both hold until reset.
- Bytes arriving in DONE are not accepted (rready_o=0). The loader never writes memory again until reset.
- Word index compare is against ENTRIES-1 at full width. Non-power-of-two ENTRIES are legal; the index never exceeds ENTRIES-1.
- No timeout: an incomplete stream leaves the loader waiting indefinitely with cpu_rst_o=1.
- imem_we_o and dmem_we_o are never high in the same cycle.

Test Plan (IMEM_ENTRIES=4, DMEM_ENTRIES=2 unless noted):
1. Reset, then send bytes 13 00 00 00 -> imem_we_o pulses once, imem_addr_o=0, imem_wdata_o=32'h0000_0013, one cycle after the 4th handshake; cpu_rst_o stays 1.
2. Full stream of 24 bytes, imem words 11111111..44444444 then dmem AABBCCDD, 00000777, each sent LSB first:
   - imem addr 0..3 written in order, then dmem addr 0..1 written in order.
   - done_o=1 and cpu_rst_o=0 one cycle after the dmem addr 1 write; rready_o=0 afterwards.
3. rvalid_i held high with a new byte every cycle for all 24 bytes -> identical writes to scenario 2; no byte lost; no cycle with both we_o high.
4. rvalid_i toggling randomly with gaps of 0–20 cycles -> same memory contents as scenario 2.
5. Reset pulsed low after 6 bytes, then the full 24-byte stream -> first write is imem addr 0 with the new data; no stale bytes from before reset.
6. DMEM_ENTRIES=0, 16 bytes sent -> four imem writes, then done_o=1 and cpu_rst_o=0; dmem_we_o never asserts; a 17th byte is not accepted.
